// File: rtl/exmem_pkg.sv
// exmem_pkg
//   Shared definitions for the EX/MEM pipeline stage register.
//   - Default payload/control widths.
//   - entry_t: one EX/MEM entry at default widths. Field order matches the
//     flat packing used inside exmem_pipe_reg.
//   - NOP_ENTRY: the all-zero bubble entry.
//   - is_bubble(): an entry whose MEM control field is zero is stored as a NOP.
//     The argument is a wide, zero-extended control field, so one function
//     serves any CW up to CTRL_MAX_W.
package exmem_pkg;

  localparam int DEF_DW     = 16;
  localparam int DEF_BW     = 8;
  localparam int DEF_CW     = 4;
  localparam int DEF_FW     = 4;
  localparam int DEF_BCW    = 16;
  localparam int CTRL_MAX_W = 32;

  typedef struct packed {
    logic [DEF_DW-1:0] upper;
    logic [DEF_DW-1:0] lower;
    logic [DEF_DW-1:0] word;
    logic [DEF_BW-1:0] data_byte;
    logic [DEF_FW-1:0] fwd;
    logic [DEF_CW-1:0] ctrl_w;
    logic [DEF_CW-1:0] ctrl_m;
  } entry_t;

  localparam entry_t NOP_ENTRY = '0;

  function automatic logic is_bubble(input logic [CTRL_MAX_W-1:0] ctrl_m);
    return (ctrl_m == '0);
  endfunction

endpackage

// File: rtl/exmem_slot.sv
// exmem_slot
//   One entry register with a valid flag. Clear wins over load. The data
//   register is zeroed on clear so that a dropped entry leaves nothing behind.
// Ports:
//   clk      clock (rising edge)
//   rst      asynchronous reset, active low
//   i_load   capture i_data and set valid
//   i_clear  drop the entry (valid = 0, data = 0)
//   i_data   entry to capture
//   o_valid  entry present
//   o_data   stored entry
module exmem_slot
  import exmem_pkg::*;
#(
  parameter int EW = $bits(entry_t)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_clear,
  input  logic [EW-1:0] i_data,
  output logic          o_valid,
  output logic [EW-1:0] o_data
);

  logic          r_valid;
  logic [EW-1:0] r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/exmem_pipe_reg.sv
// exmem_pipe_reg
//   EX/MEM pipeline stage register with a valid/ready handshake, synchronous
//   flush, NOP-bubble insertion (entry with zero MEM control is stored as an
//   all-zero entry) and a saturating bubble counter.
//   Build option: define EXMEM_SKID_EN for a two-entry (main + skid) stage
//   whose in_ready depends only on state and flush. Otherwise the stage holds
//   a single entry and in_ready is combinational from out_ready.
// Ports:
//   clk, rst (async, active low), flush (synchronous, drops all entries)
//   in_valid/in_ready plus in_upper/lower/word/byte/fwd/ctrl_w/ctrl_m  EX side
//   out_valid/out_ready plus out_* fields (zero when out_valid = 0)     MEM side
//   bubble_cnt  bubbles inserted since reset, saturating
module exmem_pipe_reg
  import exmem_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int BW  = DEF_BW,
  parameter int CW  = DEF_CW,
  parameter int FW  = DEF_FW,
  parameter int BCW = DEF_BCW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_upper,
  input  logic [DW-1:0]  in_lower,
  input  logic [DW-1:0]  in_word,
  input  logic [BW-1:0]  in_byte,
  input  logic [FW-1:0]  in_fwd,
  input  logic [CW-1:0]  in_ctrl_w,
  input  logic [CW-1:0]  in_ctrl_m,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_upper,
  output logic [DW-1:0]  out_lower,
  output logic [DW-1:0]  out_word,
  output logic [BW-1:0]  out_byte,
  output logic [FW-1:0]  out_fwd,
  output logic [CW-1:0]  out_ctrl_w,
  output logic [CW-1:0]  out_ctrl_m,
  output logic [BCW-1:0] bubble_cnt
);

  localparam int EW = 3*DW + BW + FW + 2*CW;

  logic [CTRL_MAX_W-1:0] w_ctrl_m_ext;
  logic                  w_in_bubble;
  logic [EW-1:0]         w_in_entry;
  logic                  w_accept;
  logic                  w_consume;
  logic                  w_main_valid;
  logic                  w_main_load;
  logic                  w_main_clear;
  logic [EW-1:0]         w_main_d;
  logic [EW-1:0]         w_main_data;
  logic [EW-1:0]         w_out_entry;
  logic [BCW-1:0]        r_bubble_cnt;

  assign w_ctrl_m_ext = CTRL_MAX_W'(in_ctrl_m);
  assign w_in_bubble  = is_bubble(w_ctrl_m_ext);
  assign w_in_entry   = w_in_bubble ? EW'(NOP_ENTRY)
                                    : {in_upper, in_lower, in_word, in_byte,
                                       in_fwd, in_ctrl_w, in_ctrl_m};

  // in_ready already carries !flush, so no accept can happen in a flush cycle.
  assign w_accept  = in_valid && in_ready;
  assign w_consume = w_main_valid && out_ready;

`ifdef EXMEM_SKID_EN
  logic          w_skid_valid;
  logic          w_skid_load;
  logic          w_skid_clear;
  logic [EW-1:0] w_skid_data;

  // Depends only on the skid flag and flush: no path from out_ready.
  assign in_ready = !w_skid_valid && !flush;

  // While skid is full in_ready is low, so main refills either from skid
  // (skid full) or from the input (skid empty), never both.
  assign w_main_load  = (w_accept && (!w_main_valid || w_consume)) ||
                        (w_consume && w_skid_valid);
  assign w_main_d     = w_skid_valid ? w_skid_data : w_in_entry;
  assign w_main_clear = flush || (w_consume && !w_skid_valid && !w_accept);

  // Input lands in skid only when main is occupied and not leaving.
  assign w_skid_load  = w_accept && w_main_valid && !w_consume;
  assign w_skid_clear = flush || (w_consume && w_skid_valid);

  exmem_slot #(.EW(EW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (w_in_entry),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );
`else
  assign in_ready     = (out_ready || !w_main_valid) && !flush;
  assign w_main_load  = w_accept;
  assign w_main_d     = w_in_entry;
  // Accept together with consume replaces the entry in place.
  assign w_main_clear = flush || (w_consume && !w_accept);
`endif

  exmem_slot #(.EW(EW)) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_d),
    .o_valid (w_main_valid),
    .o_data  (w_main_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bubble_cnt <= '0;
    end else if (w_accept && w_in_bubble && (r_bubble_cnt != '1)) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign w_out_entry = w_main_valid ? w_main_data : '0;
  assign {out_upper, out_lower, out_word, out_byte,
          out_fwd, out_ctrl_w, out_ctrl_m} = w_out_entry;
  assign out_valid   = w_main_valid;
  assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// tb_exmem_pipe_reg
//   Scoreboard bench: entries are pushed to a model queue when accepted and
//   popped when consumed. Default widths. Define EXMEM_SKID_EN for both the
//   DUT and this bench to exercise the two-entry build.
module tb_exmem_pipe_reg;
  import exmem_pkg::*;

`ifdef EXMEM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_upper, in_lower, in_word;
  logic [7:0]  in_byte;
  logic [3:0]  in_fwd, in_ctrl_w, in_ctrl_m;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_upper, out_lower, out_word;
  logic [7:0]  out_byte;
  logic [3:0]  out_fwd, out_ctrl_w, out_ctrl_m;
  logic [15:0] bubble_cnt;

  entry_t      dut_out;
  entry_t      sb_q[$];
  logic [15:0] exp_bcnt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  exmem_pipe_reg dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_upper   (in_upper),
    .in_lower   (in_lower),
    .in_word    (in_word),
    .in_byte    (in_byte),
    .in_fwd     (in_fwd),
    .in_ctrl_w  (in_ctrl_w),
    .in_ctrl_m  (in_ctrl_m),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_upper  (out_upper),
    .out_lower  (out_lower),
    .out_word   (out_word),
    .out_byte   (out_byte),
    .out_fwd    (out_fwd),
    .out_ctrl_w (out_ctrl_w),
    .out_ctrl_m (out_ctrl_m),
    .bubble_cnt (bubble_cnt)
  );

  assign dut_out = {out_upper, out_lower, out_word, out_byte,
                    out_fwd, out_ctrl_w, out_ctrl_m};

  // ---------------- model ----------------
  function automatic logic exp_ready();
    if (flush) return 1'b0;
    if (CAP == 2) return (sb_q.size() < 2);
    return (out_ready || (sb_q.size() == 0));
  endfunction

  function automatic entry_t exp_out();
    if (sb_q.size() > 0) return sb_q[0];
    return NOP_ENTRY;
  endfunction

  task automatic drive(input logic v, input logic [15:0] w,
                       input logic [3:0] cm, input logic [3:0] f);
    in_valid  = v;
    in_word   = w;
    in_upper  = w ^ 16'hA5A5;
    in_lower  = ~w;
    in_byte   = w[7:0] ^ 8'h3C;
    in_fwd    = f;
    in_ctrl_w = cm ^ 4'h9;
    in_ctrl_m = cm;
  endtask

  // Advance one clock and update the scoreboard with what the handshake
  // should have done at that edge. Returns on the following falling edge.
  task automatic tick();
    logic   acc;
    logic   con;
    entry_t e;
    acc = in_valid && exp_ready();
    con = (sb_q.size() > 0) && out_ready;
    if (in_ctrl_m == 4'h0) e = NOP_ENTRY;
    else e = {in_upper, in_lower, in_word, in_byte, in_fwd, in_ctrl_w, in_ctrl_m};
    @(posedge clk);
    if (flush) begin
      sb_q.delete();
    end else begin
      if (con) void'(sb_q.pop_front());
      if (acc) begin
        sb_q.push_back(e);
        if (in_ctrl_m == 4'h0 && exp_bcnt != 16'hFFFF) exp_bcnt = exp_bcnt + 16'd1;
      end
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    sb_q.delete(); exp_bcnt = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (dut_out !== NOP_ENTRY) begin errors++; $display("FAIL reset_out got %h want 0", dut_out); end
    checks++; if (bubble_cnt !== 16'h0) begin errors++; $display("FAIL reset_bcnt got %h want 0", bubble_cnt); end
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
    // Hold a bubble, then pull reset asynchronously mid-cycle.
    drive(1'b1, 16'hBEEF, 4'h0, 4'h7);
    tick();
    drive(1'b0, 16'h0, 4'h1, 4'h0);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got %b want 1", out_valid); end
    checks++; if (bubble_cnt !== 16'h1) begin errors++; $display("FAIL midrst_pre_bcnt got %h want 1", bubble_cnt); end
    #2 rst = 1'b0;
    #1;
    sb_q.delete(); exp_bcnt = 16'h0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
    checks++; if (out_word !== 16'h0) begin errors++; $display("FAIL midrst_word got %h want 0", out_word); end
    checks++; if (bubble_cnt !== 16'h0) begin errors++; $display("FAIL midrst_bcnt got %h want 0", bubble_cnt); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_post_valid got %b want 0", out_valid); end
  endtask

  task automatic test_passthrough();
    out_ready = 1'b1;
    drive(1'b1, 16'h1234, 4'h3, 4'h5);
    tick();
    drive(1'b0, 16'h0, 4'h1, 4'h0);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pass_valid got %b want 1", out_valid); end
    checks++; if (out_word !== 16'h1234) begin errors++; $display("FAIL pass_word got %h want 1234", out_word); end
    checks++; if (out_ctrl_m !== 4'h3) begin errors++; $display("FAIL pass_ctrl_m got %h want 3", out_ctrl_m); end
    checks++; if (out_fwd !== 4'h5) begin errors++; $display("FAIL pass_fwd got %h want 5", out_fwd); end
    checks++; if (dut_out !== exp_out()) begin errors++; $display("FAIL pass_entry got %h want %h", dut_out, exp_out()); end
    tick();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_drain got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'(i * 16'h0111 + 16'h0001), 4'((i % 15) + 1), 4'(i));
      tick();
      #1;
      checks++; if (dut_out !== exp_out() || out_valid !== 1'b1 || sb_q.size() != 1)
        begin errors++; $display("FAIL b2b_entry%0d got %h want %h", i, dut_out, exp_out()); end
    end
    drive(1'b0, 16'h0, 4'h1, 4'h0);
    tick();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_bubble();
    out_ready = 1'b1;
    drive(1'b1, 16'hBEEF, 4'h0, 4'h7);
    tick();
    drive(1'b0, 16'h0, 4'h1, 4'h0);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bub_valid got %b want 1", out_valid); end
    checks++; if (out_word !== 16'h0) begin errors++; $display("FAIL bub_word got %h want 0", out_word); end
    checks++; if (out_fwd !== 4'h0) begin errors++; $display("FAIL bub_fwd got %h want 0", out_fwd); end
    checks++; if (dut_out !== NOP_ENTRY) begin errors++; $display("FAIL bub_entry got %h want 0", dut_out); end
    checks++; if (bubble_cnt !== 16'h1) begin errors++; $display("FAIL bub_cnt got %h want 1", bubble_cnt); end
    tick();
  endtask

  task automatic test_stall();
    logic [15:0] pend[$];
    logic [15:0] got[$];
    pend = '{16'h0001, 16'h0002};
    for (int c = 0; c < 8; c++) begin
      out_ready = (c >= 3);
      if (pend.size() > 0) drive(1'b1, pend[0], 4'h1, 4'h2);
      else drive(1'b0, 16'h0, 4'h1, 4'h0);
      #1;
      if (c == 2) begin
        checks++; if (out_word !== 16'h0001) begin errors++; $display("FAIL stall_hold got %h want 0001", out_word); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b want 0", in_ready); end
      end
      if (out_valid && out_ready) got.push_back(out_word);
      if (in_valid && exp_ready()) void'(pend.pop_front());
      tick();
    end
    checks++; if (got.size() != 2) begin errors++; $display("FAIL stall_count got %0d want 2", got.size()); end
    else begin
      checks++; if (got[0] !== 16'h0001 || got[1] !== 16'h0002)
        begin errors++; $display("FAIL stall_order got %h,%h want 0001,0002", got[0], got[1]); end
    end
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < CAP; i++) begin
      drive(1'b1, 16'(16'h0A00 + i), 4'h2, 4'h1);
      tick();
    end
    flush = 1'b1;
    drive(1'b1, 16'h0077, 4'h3, 4'h3);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got %b want 1", out_valid); end
    tick();
    flush = 1'b0;
    drive(1'b0, 16'h0, 4'h1, 4'h0);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", out_valid); end
    checks++; if (dut_out !== NOP_ENTRY) begin errors++; $display("FAIL flush_out got %h want 0", dut_out); end
    checks++; if (bubble_cnt !== exp_bcnt) begin errors++; $display("FAIL flush_bcnt got %h want %h", bubble_cnt, exp_bcnt); end
    out_ready = 1'b1;
    tick();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_noaccept got %b want 0", out_valid); end
  endtask

  task automatic test_stress();
    for (int c = 0; c < 10000; c++) begin
      flush     = ($urandom_range(0, 99) < 3);
      out_ready = ($urandom_range(0, 99) < 60);
      drive($urandom_range(0, 99) < 70, 16'($urandom), 4'($urandom_range(0, 15)), 4'($urandom));
      #1;
      checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL stress_ready c=%0d got %b want %b", c, in_ready, exp_ready()); end
      checks++; if (out_valid !== (sb_q.size() != 0)) begin errors++; $display("FAIL stress_valid c=%0d got %b want %b", c, out_valid, sb_q.size() != 0); end
      checks++; if (dut_out !== exp_out()) begin errors++; $display("FAIL stress_entry c=%0d got %h want %h", c, dut_out, exp_out()); end
      checks++; if (bubble_cnt !== exp_bcnt) begin errors++; $display("FAIL stress_bcnt c=%0d got %h want %h", c, bubble_cnt, exp_bcnt); end
      tick();
    end
    flush = 1'b0;
  endtask

  task automatic test_bubble_saturate();
    out_ready = 1'b1;
    flush     = 1'b0;
    drive(1'b1, 16'hBEEF, 4'h0, 4'h7);
    repeat (65536 + 3) tick();
    drive(1'b0, 16'h0, 4'h1, 4'h0);
    #1;
    checks++; if (bubble_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt got %h want FFFF", bubble_cnt); end
    checks++; if (bubble_cnt !== exp_bcnt) begin errors++; $display("FAIL sat_model got %h want %h", bubble_cnt, exp_bcnt); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_back_to_back();
    test_bubble();
    test_stall();
    test_flush();
    test_stress();
    test_bubble_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
